lsu_issue_ctrl: RTL and testbench

In-order issue controller in front of the single-ported lsu. It buffers memory ops dispatched from the reservation stations in a small FIFO, and issues one op at a time to the lsu when it is idle. It tracks the single in-flight op and returns its completion to the ROB/CDB with the op's tag. It also supports a pipeline flush.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/mem_op_fifo.sv | 48 ++++
 rtl/lsu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_lsu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: opcodes, the queued memory-op record and op-kind decode shared by the issue controller and its FIFO
package lsu_pkg;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam int LSU_TAG_W = 4;
    typedef logic [LSU_TAG_W-1:0] lsu_tag_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        lsu_tag_t    tag;
    } mem_op_t;
    function automatic logic is_load_op(input logic [6:0] opc);
        return opc == OPC_LOAD;
    endfunction
endpackage

// File: rtl/mem_op_fifo.sv
// mem_op_fifo: synchronous FIFO of mem_op_t with flush (priority over push/pop) and occupancy count
module mem_op_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  mem_op_t       data_i,
    output mem_op_t       data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    mem_op_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    assign full_o  = count_q[AW];
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    always_comb begin
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(do_push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(do_pop);
        count_d  = flush_i ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/lsu_issue_ctrl.sv
// lsu_issue_ctrl: in-order issue of queued memory ops to a single-ported lsu with one op in flight and registered completion
module lsu_issue_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [31:0]              enq_pc_i,
    input  logic [31:0]              enq_inst_i,
    input  logic [31:0]              enq_rs1_i,
    input  logic [31:0]              enq_rs2_i,
    input  logic [TAG_W-1:0]         enq_tag_i,
    input  logic                     flush_i,
    output logic                     lsu_request_o,
    output logic [31:0]              lsu_pc_o,
    output logic [31:0]              lsu_inst_o,
    output logic [31:0]              lsu_rs1_o,
    output logic [31:0]              lsu_rs2_o,
    input  logic                     lsu_busy_i,
    input  logic                     lsu_wb_valid_i,
    input  logic [31:0]              lsu_wb_value_i,
    output logic                     cmp_valid_o,
    output logic [TAG_W-1:0]         cmp_tag_o,
    output logic [31:0]              cmp_value_o,
    output logic                     cmp_is_store_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    typedef enum logic {IDLE, WAIT} state_e;
    state_e state_q, state_d;
    mem_op_t enq_op, head;
    logic empty, full, done;
    logic [TAG_W-1:0] tag_q, tag_d, cmp_tag_q, cmp_tag_d;
    logic is_store_q, is_store_d, drop_q, drop_d;
    logic cmp_valid_q, cmp_valid_d, cmp_is_store_q, cmp_is_store_d;
    logic [31:0] cmp_value_q, cmp_value_d;
    assign enq_op = '{pc: enq_pc_i, inst: enq_inst_i, rs1: enq_rs1_i, rs2: enq_rs2_i, tag: lsu_tag_t'(enq_tag_i)};
    mem_op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (enq_valid_i),
        .pop_i   (lsu_request_o),
        .flush_i (flush_i),
        .data_i  (enq_op),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );
    assign enq_ready_o    = !full;
    assign lsu_pc_o       = head.pc;
    assign lsu_inst_o     = head.inst;
    assign lsu_rs1_o      = head.rs1;
    assign lsu_rs2_o      = head.rs2;
    assign cmp_valid_o    = cmp_valid_q;
    assign cmp_tag_o      = cmp_tag_q;
    assign cmp_value_o    = cmp_value_q;
    assign cmp_is_store_o = cmp_is_store_q;
    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        is_store_d     = is_store_q;
        drop_d         = drop_q;
        cmp_valid_d    = 1'b0;
        cmp_tag_d      = cmp_tag_q;
        cmp_value_d    = cmp_value_q;
        cmp_is_store_d = cmp_is_store_q;
        lsu_request_o  = state_q == IDLE && !empty && !lsu_busy_i && !flush_i;
        done           = is_store_q ? !lsu_busy_i : lsu_wb_valid_i;
        if (lsu_request_o) begin
            state_d    = WAIT;
            tag_d      = TAG_W'(head.tag);
            is_store_d = !is_load_op(head.inst[6:0]);
            drop_d     = 1'b0;
        end else if (state_q == WAIT) begin
            // a flush landing on the completion cycle still squashes the result
            drop_d = drop_q || flush_i;
            if (done) begin
                state_d     = IDLE;
                cmp_valid_d = !drop_d;
                if (!drop_d) begin
                    cmp_tag_d      = tag_q;
                    cmp_value_d    = is_store_q ? '0 : lsu_wb_value_i;
                    cmp_is_store_d = is_store_q;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= IDLE;
            tag_q          <= '0;
            is_store_q     <= 1'b0;
            drop_q         <= 1'b0;
            cmp_valid_q    <= 1'b0;
            cmp_tag_q      <= '0;
            cmp_value_q    <= '0;
            cmp_is_store_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tag_q          <= tag_d;
            is_store_q     <= is_store_d;
            drop_q         <= drop_d;
            cmp_valid_q    <= cmp_valid_d;
            cmp_tag_q      <= cmp_tag_d;
            cmp_value_q    <= cmp_value_d;
            cmp_is_store_q <= cmp_is_store_d;
        end
    end
endmodule

// File: tb/tb_lsu_issue_ctrl.sv
// tb_lsu_issue_ctrl: scoreboard bench for lsu_issue_ctrl driving a behavioural byte-memory lsu
`timescale 1ns/1ps
module tb_lsu_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      value;
        logic             st;
    } exp_t;

    logic clk_i = 1'b0, reset_i = 1'b1, enq_valid_i = 1'b0, flush_i = 1'b0, force_busy = 1'b0;
    logic [31:0] enq_pc_i = '0, enq_inst_i = '0, enq_rs1_i = '0, enq_rs2_i = '0;
    logic [TAG_W-1:0] enq_tag_i = '0;
    logic enq_ready_o, lsu_request_o, lsu_busy_i, cmp_valid_o, cmp_is_store_o;
    logic [31:0] lsu_pc_o, lsu_inst_o, lsu_rs1_o, lsu_rs2_o, cmp_value_o;
    logic [TAG_W-1:0] cmp_tag_o;
    logic [$clog2(DEPTH):0] count_o;
    logic lsu_wb_valid_i = 1'b0, m_busy = 1'b0, m_load = 1'b0;
    logic [31:0] lsu_wb_value_i = '0, m_val = '0;
    logic [7:0] mem [256];
    logic [7:0] sh [256];
    logic [7:0] la;
    int m_cnt = 0, lat = 2;
    int total = 0, bad = 0, issues = 0, pulses = 0, drops = 0;
    exp_t sb[$];
    logic [63:0] iq[$];
    exp_t e;
    logic [63:0] x;

    lsu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_inst_i(enq_inst_i), .enq_rs1_i(enq_rs1_i),
        .enq_rs2_i(enq_rs2_i), .enq_tag_i(enq_tag_i), .flush_i(flush_i),
        .lsu_request_o(lsu_request_o), .lsu_pc_o(lsu_pc_o), .lsu_inst_o(lsu_inst_o),
        .lsu_rs1_o(lsu_rs1_o), .lsu_rs2_o(lsu_rs2_o), .lsu_busy_i(lsu_busy_i),
        .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_value_i(lsu_wb_value_i),
        .cmp_valid_o(cmp_valid_o), .cmp_tag_o(cmp_tag_o), .cmp_value_o(cmp_value_o),
        .cmp_is_store_o(cmp_is_store_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;
    assign lsu_busy_i = m_busy | force_busy;
    assign la = 8'(lsu_rs1_o + {{20{lsu_inst_o[31]}}, lsu_inst_o[31:20]});

    // lsu model: busy for lat cycles after a request; loads return the sign-extended byte
    always @(posedge clk_i) begin
        lsu_wb_valid_i <= 1'b0;
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy         <= 1'b0;
                lsu_wb_valid_i <= m_load;
                lsu_wb_value_i <= m_val;
            end
        end else if (lsu_request_o) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
            m_load <= lsu_inst_o[6:0] == 7'b0000011;
            m_val  <= {{24{mem[la][7]}}, mem[la]};
            if (lsu_inst_o[6:0] == 7'b0100011)
                mem[8'(lsu_rs1_o + {{20{lsu_inst_o[31]}}, lsu_inst_o[31:25], lsu_inst_o[11:7]})] <= lsu_rs2_o[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            if (cmp_valid_o) begin
                pulses++;
                total++;
                assert (sb.size() > 0) else begin
                    bad++;
                    $error("FAIL cmp_extra observed tag=%h expected=no completion", cmp_tag_o);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cmp_tag", 32'(cmp_tag_o), 32'(e.tag));
                    chk("cmp_value", cmp_value_o, e.value);
                    chk("cmp_is_store", 32'(cmp_is_store_o), 32'(e.st));
                end
            end
            if (lsu_request_o) begin
                chk("req_while_busy", 32'(lsu_busy_i), 32'd0);
                chk("req_before_cmp", 32'(issues), 32'(pulses + drops));
                issues++;
                total++;
                assert (iq.size() > 0) else begin
                    bad++;
                    $error("FAIL issue_extra observed inst=%h expected=no issue", lsu_inst_o);
                end
                if (iq.size() > 0) begin
                    x = iq.pop_front();
                    chk("issue_pc", lsu_pc_o, x[63:32]);
                    chk("issue_inst", lsu_inst_o, x[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] lb_inst(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd3, 7'b0000011};
    endfunction
    function automatic logic [31:0] sb_inst(input logic [11:0] imm);
        return {imm[11:5], 5'd2, 5'd1, 3'b000, imm[4:0], 7'b0100011};
    endfunction

    task automatic enq(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [TAG_W-1:0] tag);
        int n = 0;
        logic [7:0] a;
        enq_pc_i = pc; enq_inst_i = inst; enq_rs1_i = rs1; enq_rs2_i = rs2; enq_tag_i = tag;
        enq_valid_i = 1'b1;
        while (!enq_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
        total++;
        assert (n < 200) else begin bad++; $error("FAIL enq_timeout observed=%0d expected<200", n); end
        if (inst[6:0] == 7'b0000011) begin
            a = 8'(rs1 + {{20{inst[31]}}, inst[31:20]});
            sb.push_back('{tag, {{24{sh[a][7]}}, sh[a]}, 1'b0});
        end else begin
            if (inst[6:0] == 7'b0100011) begin
                a = 8'(rs1 + {{20{inst[31]}}, inst[31:25], inst[11:7]});
                sh[a] = rs2[7:0];
            end
            sb.push_back('{tag, 32'd0, 1'b1});
        end
        iq.push_back({pc, inst});
        @(posedge clk_i); #1;
        enq_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || iq.size() != 0 || m_busy || count_o != 0) && n < 500) begin
            @(posedge clk_i); #1; n++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        assert (n < 500) else begin bad++; $error("FAIL drain_timeout observed=%0d expected<500", n); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; sh[i] = 8'h00; end
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_cmp_valid", 32'(cmp_valid_o), 32'd0);
        reset_i = 1'b0;
        chk("rst_ready", 32'(enq_ready_o), 32'd1);
        chk("rst_cmp_tag", 32'(cmp_tag_o), 32'd0);
        chk("rst_cmp_value", cmp_value_o, 32'd0);
        chk("rst_cmp_is_store", 32'(cmp_is_store_o), 32'd0);
        chk("rst_request", 32'(lsu_request_o), 32'd0);

        enq(32'h100, 32'h00208223, 32'd0, 32'h0000ffff, 4'd3);
        chk("store_issue_req", 32'(lsu_request_o), 32'd1);
        chk("store_issue_inst", lsu_inst_o, 32'h00208223);
        drain();
        chk("store_pulses", 32'(pulses), 32'd1);

        enq(32'h104, 32'h00400183, 32'd0, 32'd0, 4'd5);
        chk("load_issue_req", 32'(lsu_request_o), 32'd1);
        chk("load_issue_inst", lsu_inst_o, lb_inst(12'd4));
        drain();
        chk("load_pulses", 32'(pulses), 32'd2);

        lat = 3;
        force_busy = 1'b1;
        enq(32'h200, sb_inst(12'd8), 32'd0, 32'h7a, 4'd10);
        enq(32'h204, lb_inst(12'd8), 32'd0, 32'd0, 4'd11);
        enq(32'h208, 32'h00000013, 32'd0, 32'd0, 4'd12);
        enq(32'h20c, sb_inst(12'd9), 32'd0, 32'h80, 4'd13);
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_ready", 32'(enq_ready_o), 32'd0);
        enq_pc_i = 32'h210; enq_inst_i = lb_inst(12'd9); enq_rs1_i = '0; enq_rs2_i = '0; enq_tag_i = 4'd14;
        enq_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("full_held_count", 32'(count_o), 32'd4);
        chk("full_held_ready", 32'(enq_ready_o), 32'd0);
        force_busy = 1'b0;
        enq(32'h210, lb_inst(12'd9), 32'd0, 32'd0, 4'd14);
        drain();
        chk("full_pulses", 32'(pulses), 32'd7);

        lat = 6;
        enq(32'h300, lb_inst(12'd4), 32'd0, 32'd0, 4'd7);
        enq(32'h304, lb_inst(12'd8), 32'd0, 32'd0, 4'd8);
        enq(32'h308, lb_inst(12'd8), 32'd0, 32'd0, 4'd9);
        chk("flush_pre_count", 32'(count_o), 32'd2);
        flush_i = 1'b1;
        enq_pc_i = 32'h30c; enq_inst_i = lb_inst(12'd8); enq_tag_i = 4'd15;
        enq_valid_i = 1'b1;
        sb.delete();
        iq.delete();
        drops++;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        enq_valid_i = 1'b0;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_ready", 32'(enq_ready_o), 32'd1);
        enq(32'h310, lb_inst(12'd9), 32'd0, 32'd0, 4'd1);
        chk("flush_wait_no_req", 32'(lsu_request_o), 32'd0);
        drain();
        chk("flush_pulses", 32'(pulses), 32'd8);

        enq(32'h400, lb_inst(12'd8), 32'd0, 32'd0, 4'd2);
        enq(32'h404, lb_inst(12'd8), 32'd0, 32'd0, 4'd3);
        enq(32'h408, lb_inst(12'd8), 32'd0, 32'd0, 4'd4);
        enq(32'h40c, lb_inst(12'd8), 32'd0, 32'd0, 4'd5);
        chk("mid_rst_pre_count", 32'(count_o), 32'd3);
        reset_i = 1'b1;
        sb.delete();
        iq.delete();
        @(posedge clk_i); #1;
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_cmp_valid", 32'(cmp_valid_o), 32'd0);
        chk("mid_rst_request", 32'(lsu_request_o), 32'd0);
        chk("mid_rst_cmp_tag", 32'(cmp_tag_o), 32'd0);
        reset_i = 1'b0;
        issues = 0; pulses = 0; drops = 0;
        drain();
        chk("mid_rst_pulses", 32'(pulses), 32'd0);

        lat = 1;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) enq(32'h500 + 32'(i * 4), sb_inst(12'(16 + i / 2)), 32'd0, 32'(i * 17 + 3), 4'(i));
            else            enq(32'h500 + 32'(i * 4), lb_inst(12'(16 + i / 2)), 32'd0, 32'd0, 4'(i));
        end
        drain();
        chk("wrap_pulses", 32'(pulses), 32'd10);
        chk("wrap_final_count", 32'(count_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
